ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Arbitrates the single RAM port among three requesters: the coherence bus controller's memory-side data port and the two cores' icache instruction-fetch ports. The block sits directly downstream of the bus controller and consumes its dREN/dWEN/daddr/dstore. It returns dload/dwait to the bus controller and iload/iwait to each icache. It holds one grant at a time until the RAM reports ACCESS, which serialises traffic and bounds instruction-fetch starvation.

## Interface
- DATA_BURST, 2, max consecutive data grants while an instruction fetch is pending (≥1)
- CLK  in  1  clock, rising edge
- RST  in  1  reset; asynchronous, active-high
- dREN  in  1  bus controller memory read request
- dWEN  in  1  bus controller memory write request
- daddr  in  32  bus controller word address
- dstore  in  32  bus controller write data
- dload  out  32  read data to bus controller
- dwait  out  1  0 for exactly the completion cycle of a data grant, else 1
- iREN  in  2  instruction fetch request per core
- iaddr  in  2×32  fetch address per core
- iload  out  2×32  fetch data per core
- iwait  out  2  per-core wait; 0 only in that core's completion cycle
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR
- ram_err  out  1  sticky; set when ramstate==ERROR during a grant

## Operation
- States: IDLE, DATA, INSTR. Registers: state, gcore (granted core), rr_last, streak (width $clog2(DATA_BURST+1)), ram_err.
- IDLE: all ram strobes are 0 and ramaddr/ramstore are 0. Next-state selection:
  - Data pending (dREN|dWEN) and (streak<DATA_BURST or no iREN) → DATA, streak+1.
  - Else any iREN → INSTR, streak←0. Both cores requesting → gcore←!rr_last; one core requesting → that core.
  - Else stay in IDLE.
- DATA: ramaddr=daddr, ramstore=dstore.
  - dWEN=1 → ramWEN=1 and ramREN=0. A write wins if dREN and dWEN are both high.
  - Else ramREN=1.
  - ramstate==ACCESS → dwait=0, dload=ramload, next IDLE.
  - dREN and dWEN both drop before ACCESS → abort to IDLE with no acknowledge; streak is still counted.
- INSTR: ramREN=1, ramaddr=iaddr[gcore].
  - ACCESS → iwait[gcore]=0, iload[gcore]=ramload, rr_last←gcore, next IDLE.
  - iREN[gcore] drops → abort to IDLE; rr_last is unchanged.
- ramstate FREE/BUSY/ERROR → hold the current grant and outputs. ERROR also sets ram_err, which clears only on reset.
- A non-granted requester sees wait=1 and load=0.
- Reset: state IDLE, rr_last=1 (so core 0 wins the first tie), streak=0, ram_err=0, dwait=1, iwait=2'b11, all loads 0, ramREN=ramWEN=0, ramaddr=ramstore=0.

## Timing
- Load outputs and wait-low are combinational on ramstate==ACCESS within the grant state.
- Minimum latency from request to acknowledge: 1 arbitration cycle plus RAM latency. With a RAM that answers ACCESS in its first cycle, the acknowledge comes in cycle 2.
- There is always at least one IDLE cycle between grants. Requesters must drop or change their request in the cycle after their acknowledge; the bus controller's COMPLETE step satisfies this.
- Reset asserted mid-transaction forces all outputs to their reset values immediately. The in-flight request is discarded and the requester re-issues it.
- Requests that arrive while a grant is active are evaluated at the next IDLE.

## Structure
- ramstate_t and word_t come from cpu_types_pkg.
- Add arb_state_t {IDLE, DATA, INSTR} to cpu_types_pkg.
- No sub-module. The round-robin pick is a small function local to ram_arbiter.

## Test plan
- Single data read: dREN=1, daddr=0x100, RAM returns 0xDEADBEEF on its 2nd cycle → ramREN=1 and ramaddr=0x100 in cycles 1–2; dwait=0 and dload=0xDEADBEEF in cycle 2.
- Write beats read: dREN=dWEN=1, dstore=0x5 → ramWEN=1, ramREN=0, ramstore=0x5.
- Instruction tie: iREN=2'b11 after reset → core 0 served first, then core 1. A repeat tie then serves core 0 again (alternation).
- Starvation bound with DATA_BURST=2: dREN held continuously with iREN[1]=1 → grant order DATA, DATA, INSTR(1), DATA.
- Abort: iREN[0] dropped in the INSTR BUSY phase → return to IDLE, iwait stays 2'b11, rr_last unchanged.
- Error and reset: ramstate=ERROR for 3 cycles during DATA → ram_err=1 and held. Asserting RST mid-grant → all outputs at reset values in the same cycle and ram_err=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake states, data words and the
// RAM arbiter's grant states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic [1:0] {IDLE, DATA, INSTR} arb_state_t;

endpackage

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: bus-controller data port vs two icache fetch ports.
// One grant at a time, held until ACCESS; data bursts are capped while a fetch waits.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int DATA_BURST = 2
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         dREN,
  input  logic         dWEN,
  input  word_t        daddr,
  input  word_t        dstore,
  output word_t        dload,
  output logic         dwait,
  input  logic [1:0]   iREN,
  input  word_t [1:0]  iaddr,
  output word_t [1:0]  iload,
  output logic [1:0]   iwait,
  output logic         ramREN,
  output logic         ramWEN,
  output word_t        ramaddr,
  output word_t        ramstore,
  input  word_t        ramload,
  input  ramstate_t    ramstate,
  output logic         ram_err
);

  localparam int SW = $clog2(DATA_BURST + 1);
  localparam logic [SW-1:0] BURST = SW'(DATA_BURST);

  arb_state_t    state;
  logic          gcore;
  logic          rr_last;
  logic [SW-1:0] streak;
  logic          d_req;
  logic          ack;

  assign d_req = dREN | dWEN;
  assign ack   = (ramstate == ACCESS);

  // Tie goes to the core that was not served last.
  function automatic logic pick_core(input logic [1:0] req, input logic last);
    if (req == 2'b11) return ~last;
    return req[1];
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      gcore   <= 1'b0;
      rr_last <= 1'b1;
      streak  <= '0;
      ram_err <= 1'b0;
    end else begin
      if (state != IDLE && ramstate == ERROR) ram_err <= 1'b1;
      case (state)
        IDLE: begin
          if (d_req && (streak < BURST || iREN == 2'b00)) begin
            state <= DATA;
            // Saturate so an idle fetch side cannot wrap the count.
            if (streak != BURST) streak <= streak + 1'b1;
          end else if (|iREN) begin
            state  <= INSTR;
            streak <= '0;
            gcore  <= pick_core(iREN, rr_last);
          end
        end
        DATA: begin
          if (ack || !d_req) state <= IDLE;
        end
        INSTR: begin
          if (ack) begin
            state   <= IDLE;
            rr_last <= gcore;
          end else if (!iREN[gcore]) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    dload    = '0;
    dwait    = 1'b1;
    iload    = '0;
    iwait    = 2'b11;
    case (state)
      DATA: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = ~dWEN;
        if (ack) begin
          dwait = 1'b0;
          dload = ramload;
        end
      end
      INSTR: begin
        ramREN  = 1'b1;
        ramaddr = iaddr[gcore];
        if (ack) begin
          iwait[gcore] = 1'b0;
          iload[gcore] = ramload;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus a randomized run against
// a grant-owner reference model.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  logic        CLK, RST;
  logic        dREN, dWEN;
  word_t       daddr, dstore, dload;
  logic        dwait;
  logic [1:0]  iREN;
  word_t [1:0] iaddr;
  word_t [1:0] iload;
  logic [1:0]  iwait;
  logic        ramREN, ramWEN;
  word_t       ramaddr, ramstore, ramload;
  ramstate_t   ramstate;
  logic        ram_err;

  int checks = 0;
  int failures = 0;

  ram_arbiter #(.DATA_BURST(2)) dut (
    .CLK(CLK), .RST(RST), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait), .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ram_err(ram_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(negedge CLK);
  endtask

  task automatic test_reset;
    RST = 1'b1; dREN = 0; dWEN = 0; daddr = 0; dstore = 0; iREN = 0; iaddr = '0;
    ramload = 0; ramstate = FREE;
    tick; tick; #1;
    checks++;
    if ({ramREN, ramWEN, dwait, iwait, ram_err} !== 6'b001110) begin
      failures++; $display("FAIL reset_ctl got=%b exp=001110", {ramREN, ramWEN, dwait, iwait, ram_err});
    end
    checks++;
    if ({ramaddr, ramstore, dload, iload} !== '0) begin
      failures++; $display("FAIL reset_data addr=%h store=%h dload=%h iload=%h exp=0", ramaddr, ramstore, dload, iload);
    end
    tick; RST = 1'b0;
  endtask

  task automatic test_data_read;
    tick; dREN = 1; daddr = 32'h100; ramstate = BUSY; #1;
    checks++;
    if (ramREN !== 1'b0) begin failures++; $display("FAIL rd_arb ramREN=%b exp=0", ramREN); end
    tick; #1;
    checks++;
    if ({ramREN, dwait} !== 2'b11 || ramaddr !== 32'h100) begin
      failures++; $display("FAIL rd_busy ren=%b dwait=%b addr=%h exp=1 1 100", ramREN, dwait, ramaddr);
    end
    tick; ramstate = ACCESS; ramload = 32'hDEADBEEF; #1;
    checks++;
    if ({ramREN, dwait, iwait} !== 4'b1011 || ramaddr !== 32'h100 || dload !== 32'hDEADBEEF || iload !== '0) begin
      failures++; $display("FAIL rd_ack ren=%b dwait=%b iwait=%b addr=%h dload=%h exp=1 0 11 100 deadbeef",
                           ramREN, dwait, iwait, ramaddr, dload);
    end
    tick; dREN = 0; ramstate = FREE; #1;
    checks++;
    if ({ramREN, dwait} !== 2'b01 || dload !== 0) begin
      failures++; $display("FAIL rd_idle ren=%b dwait=%b dload=%h exp=0 1 0", ramREN, dwait, dload);
    end
  endtask

  task automatic test_write_wins;
    tick; dREN = 1; dWEN = 1; dstore = 32'h5; daddr = 32'h20; ramstate = BUSY;
    tick; #1;
    checks++;
    if ({ramWEN, ramREN} !== 2'b10 || ramstore !== 32'h5 || ramaddr !== 32'h20) begin
      failures++; $display("FAIL wr_wins wen=%b ren=%b store=%h addr=%h exp=1 0 5 20", ramWEN, ramREN, ramstore, ramaddr);
    end
    tick; ramstate = ACCESS; #1;
    checks++;
    if (dwait !== 1'b0) begin failures++; $display("FAIL wr_ack dwait=%b exp=0", dwait); end
    tick; dREN = 0; dWEN = 0; ramstate = FREE;
  endtask

  task automatic test_instr_tie;
    tick; iREN = 2'b11; iaddr[0] = 32'h400; iaddr[1] = 32'h800; ramstate = BUSY;
    tick; ramstate = ACCESS; ramload = 32'hA0; #1;
    checks++;
    if (ramaddr !== 32'h400 || {ramREN, dwait, iwait} !== 4'b1110 || iload[0] !== 32'hA0 || iload[1] !== 0) begin
      failures++; $display("FAIL tie_first addr=%h ren=%b dwait=%b iwait=%b iload=%h exp=400 1 1 10",
                           ramaddr, ramREN, dwait, iwait, iload);
    end
    tick; iREN = 2'b10; ramstate = BUSY; #1;
    checks++;
    if ({ramREN, iwait} !== 3'b011) begin failures++; $display("FAIL tie_gap ren=%b iwait=%b exp=0 11", ramREN, iwait); end
    tick; ramstate = ACCESS; ramload = 32'hB1; #1;
    checks++;
    if (ramaddr !== 32'h800 || iwait !== 2'b01 || iload[1] !== 32'hB1 || iload[0] !== 0) begin
      failures++; $display("FAIL tie_second addr=%h iwait=%b iload=%h exp=800 01", ramaddr, iwait, iload);
    end
    tick; iREN = 2'b00; ramstate = FREE;
    tick; iREN = 2'b11; ramstate = BUSY;
    tick; ramstate = ACCESS; ramload = 32'hC2; #1;
    checks++;
    if (ramaddr !== 32'h400 || iwait !== 2'b10) begin
      failures++; $display("FAIL tie_alternate addr=%h iwait=%b exp=400 10", ramaddr, iwait);
    end
    tick; iREN = 2'b00; ramstate = FREE;
  endtask

  task automatic test_starvation;
    word_t got[4];
    word_t exp_order[4];
    int n = 0;
    bit drop_i = 0;
    exp_order[0] = 32'h100; exp_order[1] = 32'h100; exp_order[2] = 32'h800; exp_order[3] = 32'h100;
    tick; dREN = 1; daddr = 32'h100; iREN = 2'b10; iaddr[1] = 32'h800; ramstate = ACCESS;
    for (int cyc = 0; cyc < 30 && n < 4; cyc++) begin
      #1;
      if (!dwait || iwait != 2'b11) begin
        got[n] = ramaddr;
        if (!iwait[1]) drop_i = 1;
        n++;
      end
      tick;
      if (drop_i) iREN = 2'b00;
    end
    dREN = 0; iREN = 2'b00; ramstate = FREE;
    checks++;
    if (n !== 4) begin failures++; $display("FAIL starve_count grants=%0d exp=4", n); end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got[k] !== exp_order[k]) begin
        failures++; $display("FAIL starve_order idx=%0d addr=%h exp=%h", k, got[k], exp_order[k]);
      end
    end
  endtask

  task automatic test_abort;
    tick; iREN = 2'b01; iaddr[0] = 32'h400; iaddr[1] = 32'h800; ramstate = BUSY;
    tick; #1;
    checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h400 || iwait !== 2'b11) begin
      failures++; $display("FAIL abort_grant ren=%b addr=%h iwait=%b exp=1 400 11", ramREN, ramaddr, iwait);
    end
    tick; iREN = 2'b00; #1;
    checks++;
    if (iwait !== 2'b11) begin failures++; $display("FAIL abort_drop iwait=%b exp=11", iwait); end
    tick; #1;
    checks++;
    if ({ramREN, iwait} !== 3'b011 || ramaddr !== 0) begin
      failures++; $display("FAIL abort_idle ren=%b iwait=%b addr=%h exp=0 11 0", ramREN, iwait, ramaddr);
    end
    tick; iREN = 2'b11;
    tick; ramstate = ACCESS; ramload = 32'hD3; #1;
    checks++;
    if (ramaddr !== 32'h400 || iwait !== 2'b10) begin
      failures++; $display("FAIL abort_rr addr=%h iwait=%b exp=400 10", ramaddr, iwait);
    end
    tick; iREN = 2'b00; ramstate = FREE;
  endtask

  task automatic test_error_reset;
    tick; dREN = 1; daddr = 32'h40; ramstate = BUSY;
    tick; ramstate = ERROR;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({ramREN, dwait} !== 2'b11 || ramaddr !== 32'h40) begin
        failures++; $display("FAIL err_hold cyc=%0d ren=%b dwait=%b addr=%h exp=1 1 40", k, ramREN, dwait, ramaddr);
      end
      tick;
    end
    ramstate = BUSY; #1;
    checks++;
    if ({ram_err, ramREN} !== 2'b11) begin failures++; $display("FAIL err_set ram_err=%b ren=%b exp=1 1", ram_err, ramREN); end
    tick; #1;
    checks++;
    if (ram_err !== 1'b1) begin failures++; $display("FAIL err_sticky ram_err=%b exp=1", ram_err); end
    #2 RST = 1'b1; #1;
    checks++;
    if ({ramREN, ramWEN, dwait, iwait, ram_err} !== 6'b001110 || ramaddr !== 0 || ramstore !== 0) begin
      failures++; $display("FAIL rst_mid ctl=%b addr=%h store=%h exp=001110 0 0",
                           {ramREN, ramWEN, dwait, iwait, ram_err}, ramaddr, ramstore);
    end
    tick; RST = 1'b0; dREN = 0; ramstate = FREE;
    tick;
  endtask

  task automatic test_random;
    int owner = 0;            // 0 none, 1 data, 2 core0, 3 core1
    int m_streak = 0;
    int m_last = 1;
    bit d_ack = 0;
    bit [1:0] i_ack = 0;
    logic ex_ren, ex_wen, ex_dwait;
    logic [1:0] ex_iwait;
    word_t ex_addr, ex_store, ex_dload;
    word_t [1:0] ex_iload;
    int c, r;
    bit acc;
    tick; RST = 1; dREN = 0; dWEN = 0; iREN = 0; ramstate = FREE;
    tick; RST = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick;
      if (d_ack) begin dREN = 0; dWEN = 0; end
      else if (!(dREN | dWEN) && $urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 2);
        dREN = (r != 1); dWEN = (r != 0); daddr = $urandom; dstore = $urandom;
      end
      for (int k = 0; k < 2; k++) begin
        if (i_ack[k]) iREN[k] = 0;
        else if (!iREN[k] && $urandom_range(0, 3) == 0) begin iREN[k] = 1; iaddr[k] = $urandom; end
      end
      r = $urandom_range(0, 9);
      ramstate = (r < 4) ? ACCESS : (r < 8) ? BUSY : FREE;
      ramload = $urandom;
      #1;
      acc = (ramstate == ACCESS);
      ex_ren = 0; ex_wen = 0; ex_addr = 0; ex_store = 0; ex_dwait = 1; ex_iwait = 2'b11;
      ex_dload = 0; ex_iload = '0;
      d_ack = 0; i_ack = 0;
      if (owner == 1) begin
        ex_addr = daddr; ex_store = dstore; ex_wen = dWEN; ex_ren = !dWEN;
        if (acc) begin ex_dwait = 0; ex_dload = ramload; d_ack = 1; end
      end else if (owner >= 2) begin
        c = owner - 2;
        ex_ren = 1; ex_addr = iaddr[c];
        if (acc) begin ex_iwait[c] = 0; ex_iload[c] = ramload; i_ack[c] = 1; end
      end
      checks++;
      if ({ramREN, ramWEN, dwait, iwait} !== {ex_ren, ex_wen, ex_dwait, ex_iwait} || ramaddr !== ex_addr) begin
        failures++; $display("FAIL rand_ctl cyc=%0d ren/wen/dw/iw=%b%b%b%b addr=%h exp=%b%b%b%b %h", cyc,
                             ramREN, ramWEN, dwait, iwait, ramaddr, ex_ren, ex_wen, ex_dwait, ex_iwait, ex_addr);
      end
      checks++;
      if (dload !== ex_dload || iload !== ex_iload) begin
        failures++; $display("FAIL rand_load cyc=%0d dload=%h iload=%h exp=%h %h", cyc, dload, iload, ex_dload, ex_iload);
      end
      if (owner < 2) begin
        checks++;
        if (ramstore !== ex_store) begin
          failures++; $display("FAIL rand_store cyc=%0d store=%h exp=%h", cyc, ramstore, ex_store);
        end
      end
      // advance the grant owner from this cycle's inputs
      if (owner == 0) begin
        if ((dREN | dWEN) && (m_streak < 2 || iREN == 2'b00)) begin
          owner = 1;
          if (m_streak < 2) m_streak++;
        end else if (iREN != 2'b00) begin
          c = (iREN == 2'b11) ? 1 - m_last : (iREN[1] ? 1 : 0);
          owner = 2 + c; m_streak = 0;
        end
      end else if (owner == 1) begin
        if (acc || !(dREN | dWEN)) owner = 0;
      end else begin
        c = owner - 2;
        if (acc) begin owner = 0; m_last = c; end
        else if (!iREN[c]) owner = 0;
      end
    end
    checks++;
    if (ram_err !== 1'b0) begin failures++; $display("FAIL rand_err ram_err=%b exp=0", ram_err); end
    tick; dREN = 0; dWEN = 0; iREN = 0; ramstate = FREE;
  endtask

  initial begin
    test_reset;
    test_data_read;
    test_write_wins;
    test_instr_tie;
    test_starvation;
    test_abort;
    test_error_reset;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
